// File: rtl/bin_power_smoother_if.sv
// Stream-in / BRAM-write-out bundle for bin_power_smoother.
// The DUT connects through the slave modport; the bin source and BRAM writer use master.
interface bin_power_smoother_if #(
   parameter int unsigned BIN_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH = 9
) ();
   logic                         clear_hist;
   logic                         in_valid;
   logic                         in_ready;
   logic signed [BIN_WIDTH-1:0]  in_real;
   logic signed [BIN_WIDTH-1:0]  in_imag;
   logic                         in_last;
   logic                         wr_en;
   logic [ADDR_WIDTH-1:0]        wr_addr;
   logic [7:0]                   wr_data;
   logic                         frame_done;
   logic                         busy;

   modport master (
      output clear_hist, in_valid, in_real, in_imag, in_last,
      input  in_ready, wr_en, wr_addr, wr_data, frame_done, busy
   );

   modport slave (
      input  clear_hist, in_valid, in_real, in_imag, in_last,
      output in_ready, wr_en, wr_addr, wr_data, frame_done, busy
   );
endinterface

// File: rtl/bin_power_smoother.sv
// Per-bin power (re^2+im^2), scaled and saturated to 8 bits, with peak-hold and
// exponential decay against a history memory; emits BRAM write strobes.
module bin_power_smoother #(
   parameter int unsigned BIN_WIDTH   = 8,
   parameter int unsigned NUM_BINS    = 320,
   parameter int unsigned ADDR_WIDTH  = 9,
   parameter int unsigned POWER_SHIFT = 6,
   parameter int unsigned DECAY_SHIFT = 3
) (
   input logic                 clk,
   input logic                 reset,
   bin_power_smoother_if.slave bus
);
   localparam int unsigned PW = 2 * BIN_WIDTH;

   typedef enum logic [0:0] {StClear, StRun} state_e;

   state_e                      state_q;
   logic [ADDR_WIDTH-1:0]       clr_addr_q;
   logic [ADDR_WIDTH-1:0]       idx_q;

   logic                        s1_valid_q, s1_last_q;
   logic signed [BIN_WIDTH-1:0] s1_re_q, s1_im_q;
   logic [ADDR_WIDTH-1:0]       s1_idx_q;

   logic                        s2_valid_q, s2_last_q;
   logic [ADDR_WIDTH-1:0]       s2_idx_q;
   logic [PW-1:0]               s2_power_q;
   logic                        s2_fwd_q;
   logic [7:0]                  s2_fwd_data_q;

   logic                        wr_en_q, frame_done_q;
   logic [ADDR_WIDTH-1:0]       wr_addr_q;
   logic [7:0]                  wr_data_q;

   logic [7:0]                  hist_mem [NUM_BINS];
   logic [7:0]                  rd_data_q;

   logic                        accept, idx_wrap;
   logic signed [PW-1:0]        re_ext, im_ext, re_sq, im_sq;
   logic [PW-1:0]               power_d, scaled;
   logic [7:0]                  sat, hist_cur, decay, out_d;
   logic                        mem_we;
   logic [ADDR_WIDTH-1:0]       mem_waddr;
   logic [7:0]                  mem_wdata;

   assign accept   = (state_q == StRun) && bus.in_valid;
   assign idx_wrap = (idx_q == ADDR_WIDTH'(NUM_BINS - 1));

   always_comb begin
      re_ext  = $signed({{BIN_WIDTH{s1_re_q[BIN_WIDTH-1]}}, s1_re_q});
      im_ext  = $signed({{BIN_WIDTH{s1_im_q[BIN_WIDTH-1]}}, s1_im_q});
      re_sq   = re_ext * re_ext;
      im_sq   = im_ext * im_ext;
      power_d = $unsigned(re_sq) + $unsigned(im_sq);
   end

   // A same-bin write landing on the read edge is captured in s2_fwd_*.
   always_comb begin
      scaled   = s2_power_q >> POWER_SHIFT;
      sat      = (scaled > PW'(255)) ? 8'hFF : scaled[7:0];
      hist_cur = s2_fwd_q ? s2_fwd_data_q : rd_data_q;
      decay    = hist_cur >> DECAY_SHIFT;
      if (sat >= hist_cur) begin
         out_d = sat;
      end else if (decay != 8'd0) begin
         out_d = hist_cur - decay;
      end else if (hist_cur != 8'd0) begin
         out_d = hist_cur - 8'd1;
      end else begin
         out_d = 8'd0;
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = s2_idx_q;
      mem_wdata = out_d;
      if (!reset) begin
         if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = 8'd0;
         end else begin
            mem_we = s2_valid_q && !bus.clear_hist;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         hist_mem[mem_waddr] <= mem_wdata;
      end
      rd_data_q <= hist_mem[s1_idx_q];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StClear;
         clr_addr_q    <= '0;
         idx_q         <= '0;
         s1_valid_q    <= 1'b0;
         s1_last_q     <= 1'b0;
         s1_re_q       <= '0;
         s1_im_q       <= '0;
         s1_idx_q      <= '0;
         s2_valid_q    <= 1'b0;
         s2_last_q     <= 1'b0;
         s2_idx_q      <= '0;
         s2_power_q    <= '0;
         s2_fwd_q      <= 1'b0;
         s2_fwd_data_q <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         frame_done_q  <= 1'b0;
      end else begin
         wr_en_q      <= 1'b0;
         frame_done_q <= 1'b0;
         unique case (state_q)
            StClear: begin
               s1_valid_q <= 1'b0;
               s2_valid_q <= 1'b0;
               idx_q      <= '0;
               if (bus.clear_hist) begin
                  clr_addr_q <= '0;
               end else if (clr_addr_q == ADDR_WIDTH'(NUM_BINS - 1)) begin
                  clr_addr_q <= '0;
                  state_q    <= StRun;
               end else begin
                  clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
               end
            end
            StRun: begin
               if (bus.clear_hist) begin
                  state_q    <= StClear;
                  clr_addr_q <= '0;
                  idx_q      <= '0;
                  s1_valid_q <= 1'b0;
                  s2_valid_q <= 1'b0;
               end else begin
                  s1_valid_q <= accept;
                  if (accept) begin
                     s1_re_q   <= bus.in_real;
                     s1_im_q   <= bus.in_imag;
                     s1_idx_q  <= idx_q;
                     s1_last_q <= bus.in_last || idx_wrap;
                     idx_q     <= (bus.in_last || idx_wrap) ? '0 : idx_q + ADDR_WIDTH'(1);
                  end
                  s2_valid_q    <= s1_valid_q;
                  s2_idx_q      <= s1_idx_q;
                  s2_last_q     <= s1_last_q;
                  s2_power_q    <= power_d;
                  s2_fwd_q      <= s2_valid_q && (s2_idx_q == s1_idx_q);
                  s2_fwd_data_q <= out_d;
                  if (s2_valid_q) begin
                     wr_en_q      <= 1'b1;
                     wr_addr_q    <= s2_idx_q;
                     wr_data_q    <= out_d;
                     frame_done_q <= s2_last_q;
                  end
               end
            end
            default: state_q <= StClear;
         endcase
      end
   end

   assign bus.in_ready   = (state_q == StRun);
   assign bus.busy       = (state_q == StClear) || s1_valid_q || s2_valid_q;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_bin_power_smoother.sv
// Directed, table-driven bench for bin_power_smoother: vectors of {re, im, last} with
// hand-computed write address/data/frame_done, plus sequences for clear and reset timing.
module tb_bin_power_smoother;
   typedef struct {
      int re;
      int im;
      bit last;
      int exp_addr;
      int exp_data;
      bit exp_done;
   } vec_t;

   typedef struct {
      int addr;
      int data;
      bit done;
      int cyc;
   } wr_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;

   vec_t cur[$];
   wr_t  wr_q[$];
   int   acc_q[$];

   bin_power_smoother_if #(.BIN_WIDTH(8), .ADDR_WIDTH(9)) bus ();

   bin_power_smoother #(
      .BIN_WIDTH(8), .NUM_BINS(320), .ADDR_WIDTH(9), .POWER_SHIFT(6), .DECAY_SHIFT(3)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         wr_q.push_back('{int'(bus.wr_addr), int'(bus.wr_data), bus.frame_done, cyc});
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives cur[] back-to-back from a negedge, drains, then compares every write.
   task automatic run_cur(input string tag);
      int n;
      wr_q.delete();
      acc_q.delete();
      foreach (cur[i]) begin
         bus.in_valid = 1'b1;
         bus.in_real  = 8'(cur[i].re);
         bus.in_imag  = 8'(cur[i].im);
         bus.in_last  = cur[i].last;
         acc_q.push_back(cyc);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      repeat (6) @(negedge clk);
      chk({tag, " write count"}, wr_q.size(), cur.size());
      n = (wr_q.size() < cur.size()) ? wr_q.size() : cur.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s[%0d] addr", tag, i), wr_q[i].addr, cur[i].exp_addr);
         chk($sformatf("%s[%0d] data", tag, i), wr_q[i].data, cur[i].exp_data);
         chk($sformatf("%s[%0d] done", tag, i), int'(wr_q[i].done), int'(cur[i].exp_done));
         chk($sformatf("%s[%0d] latency", tag, i), wr_q[i].cyc - acc_q[i], 3);
      end
   endtask

   initial begin
      vec_t tbl [12] = '{
         '{127, 127, 1, 0, 255, 1},     // 32258>>6 saturates
         '{0, 0, 1, 0, 224, 1},         // back-to-back same bin: forwarding
         '{0, 0, 1, 0, 196, 1},
         '{0, 0, 0, 0, 172, 0},
         '{22, 0, 1, 1, 7, 1},          // 484>>6 = 7 over history 4
         '{0, 0, 0, 0, 151, 0},
         '{0, 0, 1, 1, 6, 1},           // history 7 decays by 1
         '{-128, -128, 0, 0, 255, 0},
         '{-128, -128, 1, 1, 255, 1},
         '{0, 0, 0, 0, 224, 0},
         '{0, 0, 1, 1, 224, 1},
         '{-128, 0, 1, 0, 255, 1}       // 16384>>6 = 256 saturates
      };
      int cnt;

      reset          = 1'b1;
      bus.clear_hist = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_real    = '0;
      bus.in_imag    = '0;
      bus.in_last    = 1'b0;

      // Reset and initial clear
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset in_ready", int'(bus.in_ready), 0);
      chk("reset wr_en", int'(bus.wr_en), 0);
      chk("reset busy", int'(bus.busy), 1);
      chk("reset wr_addr", int'(bus.wr_addr), 0);
      chk("reset wr_data", int'(bus.wr_data), 0);
      chk("reset frame_done", int'(bus.frame_done), 0);
      reset = 1'b0;
      cnt = 0;
      while (!bus.in_ready && cnt < 1000) begin
         cnt++;
         @(negedge clk);
      end
      chk("clear in_ready low cycles", cnt, 320);
      chk("clear no writes", wr_q.size(), 0);

      // Full frame, re=16
      cur.delete();
      for (int i = 0; i < 320; i++) cur.push_back('{16, 0, i == 319, i, 4, i == 319});
      run_cur("full");
      chk("idle busy", int'(bus.busy), 0);

      // Saturation, decay, forwarding on short frames
      cur.delete();
      foreach (tbl[i]) cur.push_back(tbl[i]);
      run_cur("table");

      // 321 samples with no in_last: wrap at 319
      cur.delete();
      for (int i = 0; i < 321; i++) begin
         int d;
         d = (i == 0) ? 224 : (i == 1 || i == 320) ? 196 : 4;
         cur.push_back('{16, 0, 1'b0, i % 320, d, i == 319});
      end
      run_cur("wrap");

      // clear_hist mid-frame at bin 100; a second pulse during clear restarts it
      wr_q.delete();
      for (int i = 0; i < 100; i++) begin
         bus.in_valid = 1'b1;
         bus.in_real  = 8'sd5;
         bus.in_imag  = 8'sd3;
         bus.in_last  = 1'b0;
         @(negedge clk);
      end
      bus.in_valid   = 1'b0;
      bus.clear_hist = 1'b1;
      @(negedge clk);
      cnt = 0;
      while (!bus.in_ready && cnt < 2000) begin
         cnt++;
         bus.clear_hist = (cnt == 51);
         @(negedge clk);
      end
      bus.clear_hist = 1'b0;
      chk("clear_hist in_ready low cycles", cnt, 371);
      chk("clear_hist writes before discard", wr_q.size(), 98);

      cur.delete();
      for (int i = 0; i < 320; i++) cur.push_back('{0, 0, i == 319, i, 0, i == 319});
      run_cur("cleared");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
